// File: rtl/sabana_muladd_pipe_if.sv
// Host-side bundle for the sabana multiply-add pipeline: issue strobe, operands,
// accumulate controls and the result/status outputs.
interface sabana_muladd_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
);
  logic                   start;
  logic                   mode;
  logic                   acc_clr;
  logic [LANES*WIDTH-1:0] a_in;
  logic [LANES*WIDTH-1:0] b_in;
  logic [LANES*WIDTH-1:0] c_in;
  logic [LANES*WIDTH-1:0] y_out;
  logic                   y_valid;
  logic                   finish;
  logic                   busy;

  modport master (
    output start, mode, acc_clr, a_in, b_in, c_in,
    input  y_out, y_valid, finish, busy
  );

  modport slave (
    input  start, mode, acc_clr, a_in, b_in, c_in,
    output y_out, y_valid, finish, busy
  );
endinterface

// File: rtl/sabana_muladd_pipe.sv
// Multi-lane pipelined y = a*b + c with optional per-lane accumulation at retire.
// Issue-to-y_valid latency is exactly LATENCY cycles, one issue per cycle.
module sabana_muladd_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LANES   = 4,
  parameter int unsigned LATENCY = 3
) (
  input logic                clock,
  input logic                reset,
  sabana_muladd_pipe_if.slave bus
);
  localparam int unsigned VW = LANES * WIDTH;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [VW-1:0] p_in;
  logic          ret_v;
  logic          ret_mode;
  logic [VW-1:0] ret_p;

  logic [VW-1:0] acc_q;
  logic [VW-1:0] acc_base;
  logic [VW-1:0] acc_sum;
  logic [VW-1:0] acc_nx;
  logic [VW-1:0] y_q;
  logic [VW-1:0] y_nx;
  logic          y_valid_q;
  logic          finish_q;
  logic          busy_q;
  logic [CW-1:0] count_q;
  logic [CW:0]   cnt_nx;

  // Product truncated to WIDTH before the add; everything wraps mod 2^WIDTH.
  always_comb begin
    p_in = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      p_in[i*WIDTH +: WIDTH] = bus.a_in[i*WIDTH +: WIDTH] * bus.b_in[i*WIDTH +: WIDTH]
                             + bus.c_in[i*WIDTH +: WIDTH];
    end
  end

  // LATENCY-1 delay stages sit between the issue-side arithmetic and the retire register.
  if (LATENCY == 1) begin : g_direct
    assign ret_v    = bus.start;
    assign ret_mode = bus.mode;
    assign ret_p    = p_in;
  end else begin : g_pipe
    logic [LATENCY-2:0] v_q;
    logic [LATENCY-2:0] m_q;
    logic [VW-1:0]      p_q [LATENCY-1];

    always_ff @(posedge clock) begin
      if (reset) begin
        v_q <= '0;
      end else begin
        v_q[0] <= bus.start;
        for (int unsigned i = 1; i < LATENCY - 1; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clock) begin
      m_q[0] <= bus.mode;
      p_q[0] <= p_in;
      for (int unsigned i = 1; i < LATENCY - 1; i++) begin
        m_q[i] <= m_q[i-1];
        p_q[i] <= p_q[i-1];
      end
    end

    assign ret_v    = v_q[LATENCY-2];
    assign ret_mode = m_q[LATENCY-2];
    assign ret_p    = p_q[LATENCY-2];
  end

  // Clear takes effect before the retire add, so clear+accumulate yields p.
  always_comb begin
    acc_base = '0;
    acc_sum  = '0;
    acc_nx   = '0;
    y_nx     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_base[i*WIDTH +: WIDTH] = bus.acc_clr ? '0 : acc_q[i*WIDTH +: WIDTH];
      acc_sum[i*WIDTH +: WIDTH]  = acc_base[i*WIDTH +: WIDTH] + ret_p[i*WIDTH +: WIDTH];
      acc_nx[i*WIDTH +: WIDTH]   = (ret_v && ret_mode) ? acc_sum[i*WIDTH +: WIDTH]
                                                       : acc_base[i*WIDTH +: WIDTH];
      if (!ret_v)        y_nx[i*WIDTH +: WIDTH] = y_q[i*WIDTH +: WIDTH];
      else if (ret_mode) y_nx[i*WIDTH +: WIDTH] = acc_sum[i*WIDTH +: WIDTH];
      else               y_nx[i*WIDTH +: WIDTH] = ret_p[i*WIDTH +: WIDTH];
    end
  end

  // An operation stays counted through its y_valid cycle, so busy covers T+1..T+LATENCY.
  assign cnt_nx = {1'b0, count_q} + (CW+1)'(bus.start) - (CW+1)'(y_valid_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      acc_q     <= acc_nx;
      y_q       <= y_nx;
      y_valid_q <= ret_v;
      finish_q  <= ret_v && (cnt_nx == (CW+1)'(1));
      busy_q    <= (cnt_nx != '0);
      count_q   <= cnt_nx[CW-1:0];
    end
  end

  assign bus.y_out   = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.finish  = finish_q;
  assign bus.busy    = busy_q;
endmodule
